// File: rtl/hazard_unit.sv
// Hazard, stall/flush and forwarding control for the 5-stage RV32 pipe.
// Also tracks data-memory waits and saturating stall/flush counters.
module hazard_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             ctrlf,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             ifidflush,
  output logic             pipe_en,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wcnt;
  logic          freeze;
  logic          loaduse;
  logic          stall_ev;
  logic          flush_ev;

  function automatic logic [1:0] fwd(
    input logic [4:0] rs,
    input logic [4:0] mrd,
    input logic       mwr,
    input logic [4:0] wrd,
    input logic       wwr
  );
    if (mwr && mrd != 5'd0 && mrd == rs)
      return 2'b10;
    else if (wwr && wrd != 5'd0 && wrd == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mem_req && !mem_ready)
              state_nx = WAIT;
      WAIT: if (mem_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign freeze =
    (state == IDLE && mem_req && !mem_ready) ||
    (state == WAIT && !mem_ready);

  assign loaduse = ex_memread && ex_rd != 5'd0 &&
    ((id_use_rs1 && id_rs1 == ex_rd) ||
     (id_use_rs2 && id_rs2 == ex_rd));

  // Freeze outranks branch, branch outranks load-use.
  always_comb begin
    ctrlf     = 1'b0;
    pcwrite   = 1'b1;
    ifidwrite = 1'b1;
    ifidflush = 1'b0;
    pipe_en   = 1'b1;
    stall_ev  = 1'b0;
    flush_ev  = 1'b0;
    forwarda  = fwd(ex_rs1, mem_rd, mem_regwrite,
                    wb_rd, wb_regwrite);
    forwardb  = fwd(ex_rs2, mem_rd, mem_regwrite,
                    wb_rd, wb_regwrite);
    if (reset) begin
      ctrlf     = 1'b1;
      pcwrite   = 1'b0;
      ifidwrite = 1'b0;
      ifidflush = 1'b1;
      pipe_en   = 1'b0;
      forwarda  = 2'b00;
      forwardb  = 2'b00;
    end else if (freeze) begin
      pcwrite   = 1'b0;
      ifidwrite = 1'b0;
      pipe_en   = 1'b0;
      stall_ev  = 1'b1;
    end else if (branch_taken) begin
      ctrlf     = 1'b1;
      ifidflush = 1'b1;
      flush_ev  = 1'b1;
    end else if (loaduse) begin
      ctrlf     = 1'b1;
      pcwrite   = 1'b0;
      ifidwrite = 1'b0;
      stall_ev  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT && mem_ready)
        wcnt <= '0;
      else if (state == WAIT && wcnt != TMAX)
        wcnt <= wcnt + 1'b1;
      // Sticky: set on the edge the counter lands on TIMEOUT.
      if (state == WAIT && !mem_ready && wcnt == TLAST)
        mem_timeout <= 1'b1;
      if (stall_ev && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a per-cycle reference model.
// Built with TIMEOUT=4 and 4-bit counters so saturation is reachable.
module tb_hazard_unit;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [4:0]    ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread;
  logic          branch_taken, mem_regwrite, mem_req;
  logic          mem_ready, wb_regwrite;
  logic          ctrlf, pcwrite, ifidwrite, ifidflush;
  logic          pipe_en, mem_timeout;
  logic [1:0]    forwarda, forwardb;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;
  bit run  = 1'b0;

  bit m_wait;
  int m_wcnt;
  bit m_tout;
  int m_stall;
  int m_flush;

  hazard_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread),
    .branch_taken(branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ctrlf(ctrlf), .pcwrite(pcwrite),
    .ifidwrite(ifidwrite), .ifidflush(ifidflush),
    .pipe_en(pipe_en),
    .forwarda(forwarda), .forwardb(forwardb),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int fsel(input int rs);
    if (mem_regwrite && mem_rd != 0 && int'(mem_rd) == rs)
      return 2;
    if (wb_regwrite && wb_rd != 0 && int'(wb_rd) == rs)
      return 1;
    return 0;
  endfunction

  // Reference model: checks, then advances to the next edge.
  always @(negedge clk) begin
    if (run) begin
      bit fz, lu, br, e_stall, e_flush;
      int e_cf, e_pc, e_iw, e_if, e_pe, e_fa, e_fb;
      fz = (m_wait || mem_req) && !mem_ready;
      lu = ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) ||
            (id_use_rs2 && id_rs2 == ex_rd));
      br = branch_taken;
      e_stall = 0;
      e_flush = 0;
      e_fa = fsel(int'(ex_rs1));
      e_fb = fsel(int'(ex_rs2));
      if (reset) begin
        {e_cf, e_pc, e_iw, e_if, e_pe} = {32'd1, 32'd0,
          32'd0, 32'd1, 32'd0};
        e_fa = 0;
        e_fb = 0;
      end else if (fz) begin
        {e_cf, e_pc, e_iw, e_if, e_pe} = {32'd0, 32'd0,
          32'd0, 32'd0, 32'd0};
        e_stall = 1;
      end else if (br) begin
        {e_cf, e_pc, e_iw, e_if, e_pe} = {32'd1, 32'd1,
          32'd1, 32'd1, 32'd1};
        e_flush = 1;
      end else if (lu) begin
        {e_cf, e_pc, e_iw, e_if, e_pe} = {32'd1, 32'd0,
          32'd0, 32'd0, 32'd1};
        e_stall = 1;
      end else begin
        {e_cf, e_pc, e_iw, e_if, e_pe} = {32'd0, 32'd1,
          32'd1, 32'd0, 32'd1};
      end
      chk("ctrlf", int'(ctrlf), e_cf);
      chk("pcwrite", int'(pcwrite), e_pc);
      chk("ifidwrite", int'(ifidwrite), e_iw);
      chk("ifidflush", int'(ifidflush), e_if);
      chk("pipe_en", int'(pipe_en), e_pe);
      chk("forwarda", int'(forwarda), e_fa);
      chk("forwardb", int'(forwardb), e_fb);
      chk("mem_timeout", int'(mem_timeout), int'(m_tout));
      chk("stall_cnt", int'(stall_cnt), m_stall);
      chk("flush_cnt", int'(flush_cnt), m_flush);
      if (reset) begin
        m_wait = 0; m_wcnt = 0; m_tout = 0;
        m_stall = 0; m_flush = 0;
      end else begin
        if (m_wait) begin
          if (mem_ready) begin
            m_wait = 0;
            m_wcnt = 0;
          end else begin
            if (m_wcnt < TO) m_wcnt++;
            if (m_wcnt == TO) m_tout = 1;
          end
        end else if (mem_req && !mem_ready) begin
          m_wait = 1;
        end
        if (e_stall && m_stall < SAT) m_stall++;
        if (e_flush && m_flush < SAT) m_flush++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    {id_rs1, id_rs2, ex_rs1, ex_rs2} = '0;
    {ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_memread} = '0;
    {branch_taken, mem_regwrite, wb_regwrite} = '0;
    {mem_req, mem_ready} = '0;
  endtask

  task automatic set_lu(input bit on);
    ex_memread = on;
    ex_rd      = 5'd5;
    id_rs1     = 5'd5;
    id_use_rs1 = on;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    run   = 1'b1;
    #1;
    chk("lit_rst_ctrlf", int'(ctrlf), 1);
    chk("lit_rst_pipe_en", int'(pipe_en), 0);
    tick(2);
    chk("lit_rst_stall", int'(stall_cnt), 0);
    reset = 1'b0;
    tick();
    chk("lit_idle_pcwrite", int'(pcwrite), 1);

    set_lu(1'b1);
    #1;
    chk("lit_lu_ctrlf", int'(ctrlf), 1);
    chk("lit_lu_pcwrite", int'(pcwrite), 0);
    tick();
    set_lu(1'b0);
    tick();
    chk("lit_lu_stall", int'(stall_cnt), 1);

    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk("lit_x0_ctrlf", int'(ctrlf), 0);
    tick();
    idle_in();

    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 3;
    mem_regwrite = 1; wb_regwrite = 1;
    #1;
    chk("lit_fwd_a10", int'(forwarda), 2);
    chk("lit_fwd_b00", int'(forwardb), 0);
    tick();
    mem_regwrite = 0;
    #1;
    chk("lit_fwd_a01", int'(forwarda), 1);
    tick();
    mem_rd = 0; wb_rd = 3; ex_rs1 = 0; mem_regwrite = 1;
    tick();
    idle_in();

    set_lu(1'b1);
    branch_taken = 1;
    #1;
    chk("lit_br_flush", int'(ifidflush), 1);
    chk("lit_br_pcwrite", int'(pcwrite), 1);
    tick();
    idle_in();
    chk("lit_br_cnt", int'(flush_cnt), 1);

    mem_req = 1; branch_taken = 1; set_lu(1'b1);
    tick(3);
    mem_ready = 1;
    #1;
    chk("lit_rel_pipe_en", int'(pipe_en), 1);
    tick();
    idle_in();
    chk("lit_mw_stall", int'(stall_cnt), 4);
    chk("lit_mw_flush", int'(flush_cnt), 2);

    mem_req = 1;
    tick(6);
    mem_ready = 1;
    tick();
    idle_in();
    tick();
    chk("lit_tout_sticky", int'(mem_timeout), 1);
    chk("lit_tout_stall", int'(stall_cnt), 10);

    set_lu(1'b1);
    tick(8);
    idle_in();
    chk("lit_stall_sat", int'(stall_cnt), SAT);

    mem_req = 1;
    tick(3);
    reset = 1;
    tick();
    chk("lit_rst2_stall", int'(stall_cnt), 0);
    chk("lit_rst2_tout", int'(mem_timeout), 0);
    chk("lit_rst2_ifidflush", int'(ifidflush), 1);
    reset = 0;
    idle_in();
    tick(2);
    chk("lit_post_pipe_en", int'(pipe_en), 1);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
